// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and downstream memory signals.
// The arbiter takes the slave view; the bench drives through the master view.
interface mem_arbiter_if;
    logic        mem_read_i;
    logic [31:0] mem_address_i;
    logic [31:0] mem_rdata_i;
    logic        mem_resp_i;

    logic        mem_read_d;
    logic        mem_write_d;
    logic [3:0]  mem_byte_enable_d;
    logic [31:0] mem_address_d;
    logic [31:0] mem_wdata_d;
    logic [31:0] mem_rdata_d;
    logic        mem_resp_d;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport slave (
        input  mem_read_i, mem_address_i,
        output mem_rdata_i, mem_resp_i,
        input  mem_read_d, mem_write_d, mem_byte_enable_d, mem_address_d, mem_wdata_d,
        output mem_rdata_d, mem_resp_d,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport master (
        output mem_read_i, mem_address_i,
        input  mem_rdata_i, mem_resp_i,
        output mem_read_d, mem_write_d, mem_byte_enable_d, mem_address_d, mem_wdata_d,
        input  mem_rdata_d, mem_resp_d,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one downstream memory port; one transaction in flight.
// Downstream request one cycle after grant, held from latched registers until mem_resp.
module mem_arbiter #(
    parameter bit DATA_PRIORITY = 1'b0
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant_d;
    logic        orphan;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        read_q;
    logic        write_q;

    logic req_i, req_d, tie_to_d, pick_d, serving, owner_req, forward;

    assign req_i     = bus.mem_read_i;
    assign req_d     = bus.mem_read_d | bus.mem_write_d;
    assign tie_to_d  = DATA_PRIORITY | ~last_grant_d;
    assign pick_d    = req_d & (~req_i | tie_to_d);
    assign serving   = (state == SERVE_I) | (state == SERVE_D);
    assign owner_req = (state == SERVE_D) ? req_d : req_i;
    // A requester that has gone away (or is being reset) never sees the completion.
    assign forward   = ~rst & serving & bus.mem_resp & ~orphan & owner_req;

    assign bus.mem_resp_i      = forward & (state == SERVE_I);
    assign bus.mem_resp_d      = forward & (state == SERVE_D);
    assign bus.mem_rdata_i     = bus.mem_resp_i ? bus.mem_rdata : 32'd0;
    assign bus.mem_rdata_d     = bus.mem_resp_d ? bus.mem_rdata : 32'd0;
    assign bus.mem_read        = read_q;
    assign bus.mem_write       = write_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            orphan       <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i | req_d) begin
                        if (pick_d) begin
                            state   <= SERVE_D;
                            addr_q  <= bus.mem_address_d;
                            read_q  <= bus.mem_read_d;
                            write_q <= bus.mem_write_d;
                            be_q    <= bus.mem_write_d ? bus.mem_byte_enable_d : 4'hF;
                            wdata_q <= bus.mem_write_d ? bus.mem_wdata_d : 32'd0;
                        end else begin
                            state   <= SERVE_I;
                            addr_q  <= bus.mem_address_i;
                            read_q  <= 1'b1;
                            write_q <= 1'b0;
                            be_q    <= 4'hF;
                            wdata_q <= 32'd0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_resp) begin
                        state        <= IDLE;
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        orphan       <= 1'b0;
                        last_grant_d <= (state == SERVE_D);
                    end else if (!owner_req) begin
                        orphan <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses round-robin ties, instance 1 gives the data port priority.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        rd_i, rd_d, wr_d, resp;
    logic [1:0][3:0]   be_d;
    logic [1:0][31:0]  addr_i, addr_d, wdata_d, rdata;
    logic [1:0]        o_read, o_write, o_resp_i, o_resp_d;
    logic [1:0][3:0]   o_be;
    logic [1:0][31:0]  o_addr, o_wdata, o_rdata_i, o_rdata_d;

    int   vectors = 0;
    int   miscompares = 0;
    logic [1:0] last_d;  // model: was the most recent grant on each instance the data port

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter_if bus ();
        assign bus.mem_read_i        = rd_i[g];
        assign bus.mem_address_i     = addr_i[g];
        assign bus.mem_read_d        = rd_d[g];
        assign bus.mem_write_d       = wr_d[g];
        assign bus.mem_byte_enable_d = be_d[g];
        assign bus.mem_address_d     = addr_d[g];
        assign bus.mem_wdata_d       = wdata_d[g];
        assign bus.mem_resp          = resp[g];
        assign bus.mem_rdata         = rdata[g];
        assign o_read[g]    = bus.mem_read;
        assign o_write[g]   = bus.mem_write;
        assign o_be[g]      = bus.mem_byte_enable;
        assign o_addr[g]    = bus.mem_address;
        assign o_wdata[g]   = bus.mem_wdata;
        assign o_resp_i[g]  = bus.mem_resp_i;
        assign o_resp_d[g]  = bus.mem_resp_d;
        assign o_rdata_i[g] = bus.mem_rdata_i;
        assign o_rdata_d[g] = bus.mem_rdata_d;
        mem_arbiter #(.DATA_PRIORITY(g == 1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_i = '0; rd_d = '0; wr_d = '0; resp = '0;
        be_d = '0; addr_i = '0; addr_d = '0; wdata_d = '0; rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_d = 2'b11;
    endtask

    task automatic drive_i(input int s, input logic [31:0] a);
        rd_i[s] = 1'b1;
        addr_i[s] = a;
    endtask

    task automatic drive_d(input int s, input bit w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        rd_d[s] = !w; wr_d[s] = w;
        addr_d[s] = a; wdata_d[s] = wd; be_d[s] = be;
    endtask

    task automatic drop(input int s, input bit port_d);
        if (port_d) begin rd_d[s] = 1'b0; wr_d[s] = 1'b0; end
        else rd_i[s] = 1'b0;
    endtask

    // Waits for the grant, checks the downstream request, completes it and drops the requester.
    task automatic serve_one(input int s, input bit port_d, input bit is_wr, input logic [31:0] ea,
                             input logic [31:0] ew, input logic [3:0] eb, input int exp_wait,
                             input int lat, input bit flush, input logic [31:0] rd, input string nm);
        int  w;
        bit  fwd;
        w = 0;
        do begin @(negedge clk); w++; end while (!(o_read[s] | o_write[s]) && w < 20);
        vectors++;
        if (w !== exp_wait) begin
            miscompares++;
            $display("FAIL %s grant_wait: got %0d cycles, want %0d", nm, w, exp_wait);
        end
        vectors++;
        if ({o_read[s], o_write[s], o_addr[s], o_be[s]} !== {!is_wr, is_wr, ea, eb}) begin
            miscompares++;
            $display("FAIL %s request: got rd=%b wr=%b a=%h be=%h, want rd=%b wr=%b a=%h be=%h",
                     nm, o_read[s], o_write[s], o_addr[s], o_be[s], !is_wr, is_wr, ea, eb);
        end
        if (is_wr) begin
            vectors++;
            if (o_wdata[s] !== ew) begin
                miscompares++;
                $display("FAIL %s wdata: got %h, want %h", nm, o_wdata[s], ew);
            end
        end
        if (flush) begin step(); drop(s, port_d); end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            vectors++;
            if ({o_read[s], o_write[s], o_addr[s], o_resp_i[s], o_resp_d[s]} !== {!is_wr, is_wr, ea, 2'b00}) begin
                miscompares++;
                $display("FAIL %s hold: got rd=%b wr=%b a=%h ri=%b rdd=%b", nm,
                         o_read[s], o_write[s], o_addr[s], o_resp_i[s], o_resp_d[s]);
            end
        end
        step();
        resp[s] = 1'b1;
        rdata[s] = rd;
        @(negedge clk);
        fwd = !flush;
        vectors++;
        if ({o_read[s], o_write[s], o_resp_i[s], o_resp_d[s], o_rdata_i[s], o_rdata_d[s]} !==
            {!is_wr, is_wr, fwd && !port_d, fwd && port_d,
             (fwd && !port_d) ? rd : 32'd0, (fwd && port_d) ? rd : 32'd0}) begin
            miscompares++;
            $display("FAIL %s completion: got ri=%b rdd=%b di=%h dd=%h, want forward=%b port_d=%b data=%h",
                     nm, o_resp_i[s], o_resp_d[s], o_rdata_i[s], o_rdata_d[s], fwd, port_d, rd);
        end
        step();
        resp[s] = 1'b0;
        rdata[s] = 32'd0;
        drop(s, port_d);
        last_d[s] = port_d;
        @(negedge clk);
        vectors++;
        if ({o_read[s], o_write[s], o_resp_i[s], o_resp_d[s]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s idle_after: got rd=%b wr=%b ri=%b rdd=%b", nm,
                     o_read[s], o_write[s], o_resp_i[s], o_resp_d[s]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resp = 2'b11;
        rdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        step();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            vectors++;
            if ({o_read[s], o_write[s], o_resp_i[s], o_resp_d[s], o_be[s], o_addr[s], o_wdata[s],
                 o_rdata_i[s], o_rdata_d[s]} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got rd=%b wr=%b ri=%b rdd=%b be=%h a=%h di=%h dd=%h, want all 0",
                         s, o_read[s], o_write[s], o_resp_i[s], o_resp_d[s], o_be[s], o_addr[s],
                         o_rdata_i[s], o_rdata_d[s]);
            end
        end
        do_reset();
    endtask

    task automatic test_i_read();
        do_reset();
        drive_i(0, 32'h0000_0060);
        serve_one(0, 1'b0, 1'b0, 32'h0000_0060, 32'd0, 4'hF, 2, 3, 1'b0, 32'h0000_0013, "i_read");
    endtask

    task automatic test_d_write();
        step();
        drive_d(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        serve_one(0, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 2, 2, 1'b0, 32'h1234_5678, "d_write");
    endtask

    task automatic test_tie_rr();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive_i(0, 32'h0000_0100 + r);
            drive_d(0, 1'b0, 32'h0000_2000 + r, 32'd0, 4'h0);
            serve_one(0, 1'b0, 1'b0, 32'h0000_0100 + r, 32'd0, 4'hF, 2, 2, 1'b0, $urandom, "tie_rr_first");
            serve_one(0, 1'b1, 1'b0, 32'h0000_2000 + r, 32'd0, 4'hF, 1, 2, 1'b0, $urandom, "tie_rr_second");
            step();
        end
    endtask

    task automatic test_data_priority();
        do_reset();
        drive_i(1, 32'h0000_0400);
        drive_d(1, 1'b1, 32'h0000_3000, 32'hCAFE_0001, 4'b1000);
        serve_one(1, 1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_0001, 4'b1000, 2, 2, 1'b0, $urandom, "dprio_d1");
        drive_d(1, 1'b1, 32'h0000_3004, 32'hCAFE_0002, 4'b0100);
        serve_one(1, 1'b1, 1'b1, 32'h0000_3004, 32'hCAFE_0002, 4'b0100, 1, 3, 1'b0, $urandom, "dprio_d2");
        serve_one(1, 1'b0, 1'b0, 32'h0000_0400, 32'd0, 4'hF, 1, 1, 1'b0, $urandom, "dprio_i");
    endtask

    task automatic test_flush();
        step();
        drive_i(0, 32'h0000_0080);
        serve_one(0, 1'b0, 1'b0, 32'h0000_0080, 32'd0, 4'hF, 2, 3, 1'b1, 32'hBAD0_BAD0, "flush");
        step();
        drive_i(0, 32'h0000_0084);
        serve_one(0, 1'b0, 1'b0, 32'h0000_0084, 32'd0, 4'hF, 2, 1, 1'b0, 32'h0000_0077, "after_flush");
    endtask

    task automatic test_reset_mid();
        int w;
        step();
        drive_d(0, 1'b1, 32'h0000_5000, 32'h0101_0101, 4'hF);
        w = 0;
        do begin @(negedge clk); w++; end while (!o_write[0] && w < 20);
        vectors++;
        if (o_write[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_grant: got wr=%b, want 1", o_write[0]);
        end
        step();
        rst = 1'b1;
        drop(0, 1'b1);
        step();
        rst = 1'b0;
        last_d = 2'b11;
        resp[0] = 1'b1;
        rdata[0] = 32'h5555_AAAA;
        @(negedge clk);
        vectors++;
        if ({o_write[0], o_read[0], o_resp_d[0], o_rdata_d[0]} !== 35'd0) begin
            miscompares++;
            $display("FAIL rst_mid_late_resp: got wr=%b rd=%b rdd=%b dd=%h, want all 0",
                     o_write[0], o_read[0], o_resp_d[0], o_rdata_d[0]);
        end
        step();
        resp[0] = 1'b0;
        rdata[0] = 32'd0;
        drive_i(0, 32'h0000_00C0);
        serve_one(0, 1'b0, 1'b0, 32'h0000_00C0, 32'd0, 4'hF, 2, 2, 1'b0, $urandom, "after_rst_mid");
    endtask

    // Random traffic; the expected grant order follows the tie rules and the model's last grant.
    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int s, mix, lat1, lat2;
            bit w, flush, first_d;
            logic [31:0] ai, ad, wd;
            logic [3:0]  be;
            s = $urandom_range(0, 1);
            mix = $urandom_range(0, 2);
            w = $urandom_range(0, 1);
            lat1 = $urandom_range(1, 4);
            lat2 = $urandom_range(1, 4);
            flush = (mix != 2) && ($urandom_range(0, 4) == 0);
            ai = $urandom; ad = $urandom; wd = $urandom; be = 4'($urandom);
            step();
            if (mix != 1) drive_i(s, ai);
            if (mix != 0) drive_d(s, w, ad, wd, be);
            if (mix == 2) first_d = (s == 1) || !last_d[s];
            else first_d = (mix == 1);
            if (first_d)
                serve_one(s, 1'b1, w, ad, wd, w ? be : 4'hF, 2, lat1, flush, $urandom, "rand_d");
            else
                serve_one(s, 1'b0, 1'b0, ai, 32'd0, 4'hF, 2, lat1, flush, $urandom, "rand_i");
            if (mix == 2) begin
                if (first_d)
                    serve_one(s, 1'b0, 1'b0, ai, 32'd0, 4'hF, 1, lat2, 1'b0, $urandom, "rand_i_loser");
                else
                    serve_one(s, 1'b1, w, ad, wd, w ? be : 4'hF, 1, lat2, 1'b0, $urandom, "rand_d_loser");
            end
        end
    endtask

    initial begin
        rd_i = '0; rd_d = '0; wr_d = '0; resp = '0;
        be_d = '0; addr_i = '0; addr_d = '0; wdata_d = '0; rdata = '0;
        last_d = 2'b11;
        test_reset();
        test_i_read();
        test_d_write();
        test_tie_rr();
        test_data_priority();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
